tlb_mp: RTL and testbench
=========================

// Module: tlb_mp
// PURPOSE
//  Parametrised, registered MIPS-style joint TLB for the mmu subsystem.
//  - NUM_LOOKUP independent translation ports (fetch, load/store, extra
//    pipes), each with 1-cycle registered results.
//  - Also provides: TLBR/TLBWI/TLBWR access, a CP0 Random/Wired pair,
//    a registered TLBP probe and a single-cycle global invalidate.
// PARAMETERS
//  NUM_ENTRIES  16  TLB entries; power of 2, 4..64; IDX_W = $clog2(NUM_ENTRIES)
//  NUM_LOOKUP   2   lookup ports, 1..4
//  ENTRY_W      78  entry width; fixed by the entry format below
// PORTS
//  clk           in   1              clock
//  reset         in   1              synchronous, active-high
//  asid          in   8              current EntryHi.ASID for lookup ports
//  lk_req        in   NUM_LOOKUP     per-port lookup request
//  lk_vaddr      in   NUM_LOOKUP*32  per-port virtual address; port p = [32p+31:32p]
//  lk_rsp_valid  out  NUM_LOOKUP     result valid, 1 cycle after lk_req
//  lk_miss       out  NUM_LOOKUP     no matching entry
//  lk_invalid    out  NUM_LOOKUP     hit, selected page V=0
//  lk_dirty      out  NUM_LOOKUP     selected page D bit
//  lk_cattr      out  NUM_LOOKUP*3   selected page C field
//  lk_paddr      out  NUM_LOOKUP*32  {pfn[19:0], vaddr[11:0]}
//  rw_index      in   IDX_W          TLBR/TLBWI index
//  tlbwi_we      in   1              write rw_wdata at rw_index
//  tlbwr_we      in   1              write rw_wdata at random
//  rw_wdata      in   ENTRY_W        write data
//  rw_rdata      out  ENTRY_W        entries[rw_index], combinational
//  wired_we      in   1              load Wired register
//  wired_wdata   in   IDX_W          new Wired value
//  random        out  IDX_W          CP0 Random value
//  tlbp_req      in   1              probe request
//  tlbp_entry_hi in   32             probe VPN2 [31:13], ASID [7:0]
//  tlbp_valid    out  1              probe result valid, 1 cycle after tlbp_req
//  tlbp_index    out  32             {miss, zeros, hit index}
//  flush         in   1              clear all V0/V1 bits
// BEHAVIOUR
//  Entry format, MSB to LSB:
//  - vpn2[18:0], asid[7:0], g
//  - pfn0[19:0], c0[2:0], d0, v0
//  - pfn1[19:0], c1[2:0], d1, v1
//  Match rule:
//  - Entry matches when vpn2 == vaddr[31:13] && (g || entry.asid == asid).
//  - vaddr[12] selects the odd (1) or even (0) page.
//  - Multiple hits resolve to the lowest index; no error is raised.
//  Lookup ports:
//  - Compare in the request cycle, register the result.
//  - lk_rsp_valid[p] <= lk_req[p]; all ports are independent.
//  - When !lk_req, result registers hold their previous values.
//  - A miss drives pfn=0, invalid=0, dirty=0, cattr=0.
//  Writes:
//  - A write updates the table at the clock edge.
//  - A lookup or probe issued in the same cycle as a write sees the OLD
//    table; there is no bypass.
//  - tlbwi_we && tlbwr_we together: tlbwi wins, random is still advanced.
//  - flush:
//    - Clears every v0/v1 at the edge.
//    - A write in the same cycle is applied after the flush, so the written
//      entry keeps its new V bits.
//  Random/Wired:
//  - Reset: wired=0, random=NUM_ENTRIES-1.
//  - random decrements every cycle. When random == wired (or random < wired),
//    the next value is NUM_ENTRIES-1.
//  - tlbwr_we writes at the current random value, then random advances as usual.
//  - wired_we:
//    - wired <= wired_wdata, random <= NUM_ENTRIES-1; this overrides decrement.
//    - wired_wdata >= NUM_ENTRIES is masked to IDX_W bits.
//  TLBP:
//  - Matches tlbp_entry_hi against the table using tlbp_entry_hi[7:0] as ASID,
//    registered.
//  - tlbp_index[31] = miss. On a hit, [IDX_W-1:0] = hit index; on a miss the
//    index bits are 0.
//  Reset:
//  - All entries 0 (all pages invalid, g=0).
//  - All lk_* outputs 0, tlbp_valid=0, tlbp_index=0.
//  - reset overrides any write or flush in the same cycle.
// TESTING
//  1. tlbwi idx3 {vpn2=0x00040, asid=5, pfn0=0x123, v0=1, d0=1}; then port0
//     lookup 0x00080ABC, asid 5 -> next cycle valid=1, miss=0, paddr=0x00123ABC,
//     dirty=1.
//  2. Same entry, lookup asid 6 -> miss=1; set g=1 and repeat -> hit.
//     Lookup 0x00081000 with v1=0 -> invalid=1.
//  3. tlbwi in cycle N and a lookup of the same vaddr in cycle N -> old result
//     (miss); lookup in cycle N+1 -> hit. Run all ports at once on different
//     entries.
//  4. wired_we=4 -> random=15 next cycle, then 14..4, then wraps to 15.
//     tlbwr at random=9 lands at index 9; indices 0..3 are never hit by tlbwr.
//  5. tlbp on a present entry idx7 -> tlbp_index=0x00000007 after 1 cycle.
//     Absent -> 0x80000000. Duplicate at idx2 and idx7 -> 2.
//  6. flush with a concurrent tlbwi idx1 -> all lookups invalid except idx1.
//     reset mid-run -> random=15, all outputs 0.

Source files
------------

// File: rtl/tlb_mp.sv
// ============================================================================
// Module  : tlb_mp
// Brief   : Joint MIPS-style TLB, multi-port registered lookup, TLBR/TLBWI/TLBWR,
//           Random/Wired, TLBP probe and global V-bit flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_mp #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_LOOKUP  = 2,
  parameter int ENTRY_W     = 78,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              asid,
  input  logic [NUM_LOOKUP-1:0]   lk_req,
  input  logic [NUM_LOOKUP*32-1:0] lk_vaddr,
  output logic [NUM_LOOKUP-1:0]   lk_rsp_valid,
  output logic [NUM_LOOKUP-1:0]   lk_miss,
  output logic [NUM_LOOKUP-1:0]   lk_invalid,
  output logic [NUM_LOOKUP-1:0]   lk_dirty,
  output logic [NUM_LOOKUP*3-1:0] lk_cattr,
  output logic [NUM_LOOKUP*32-1:0] lk_paddr,
  input  logic [IDX_W-1:0]        rw_index,
  input  logic                    tlbwi_we,
  input  logic                    tlbwr_we,
  input  logic [ENTRY_W-1:0]      rw_wdata,
  output logic [ENTRY_W-1:0]      rw_rdata,
  input  logic                    wired_we,
  input  logic [IDX_W-1:0]        wired_wdata,
  output logic [IDX_W-1:0]        random,
  input  logic                    tlbp_req,
  input  logic [31:0]             tlbp_entry_hi,
  output logic                    tlbp_valid,
  output logic [31:0]             tlbp_index,
  input  logic                    flush
);

  localparam int         c_VPN_LO = 59;
  localparam int         c_ASID_LO = 51;
  localparam int         c_G      = 50;
  localparam int         c_V0     = 25;
  localparam int         c_V1     = 0;
  localparam logic [IDX_W-1:0] c_MAX_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [ENTRY_W-1:0] r_ent [NUM_ENTRIES];
  logic [IDX_W-1:0]   r_wired;
  logic [IDX_W-1:0]   r_random;

  logic [NUM_LOOKUP-1:0] w_lk_hit;
  logic [IDX_W-1:0]      w_lk_idx  [NUM_LOOKUP];
  logic [ENTRY_W-1:0]    w_lk_ent  [NUM_LOOKUP];
  logic [24:0]           w_lk_page [NUM_LOOKUP];
  logic                  w_tp_hit;
  logic [IDX_W-1:0]      w_tp_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_unused;

  function automatic logic f_match(input logic [ENTRY_W-1:0] e,
                                   input logic [18:0] vpn2,
                                   input logic [7:0]  a);
    return (e[ENTRY_W-1:c_VPN_LO] == vpn2) &&
           (e[c_G] || (e[c_ASID_LO +: 8] == a));
  endfunction

  // Downward scan so the lowest matching index is the one left standing.
  always_comb begin
    for (int p = 0; p < NUM_LOOKUP; p++) begin
      w_lk_hit[p] = 1'b0;
      w_lk_idx[p] = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
        if (f_match(r_ent[i], lk_vaddr[32*p+13 +: 19], asid)) begin
          w_lk_hit[p] = 1'b1;
          w_lk_idx[p] = IDX_W'(i);
        end
      end
      w_lk_ent[p]  = r_ent[w_lk_idx[p]];
      // Page layout {pfn[19:0], c[2:0], d, v}; vaddr[12] picks odd page.
      w_lk_page[p] = lk_vaddr[32*p+12] ? w_lk_ent[p][24:0] : w_lk_ent[p][49:25];
    end
  end

  always_comb begin
    w_tp_hit = 1'b0;
    w_tp_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (f_match(r_ent[i], tlbp_entry_hi[31:13], tlbp_entry_hi[7:0])) begin
        w_tp_hit = 1'b1;
        w_tp_idx = IDX_W'(i);
      end
    end
  end

  assign w_wr_idx = tlbwi_we ? rw_index : r_random;
  assign rw_rdata = r_ent[rw_index];
  assign random   = r_random;
  assign w_unused = &{1'b0, tlbp_entry_hi[12:8]};

  // Flush first, write second: the later NBA lets a same-cycle write keep its V bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          r_ent[i][c_V0] <= 1'b0;
          r_ent[i][c_V1] <= 1'b0;
        end
      end
      if (tlbwi_we || tlbwr_we) r_ent[w_wr_idx] <= rw_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wired  <= '0;
      r_random <= c_MAX_IDX;
    end else if (wired_we) begin
      r_wired  <= wired_wdata;
      r_random <= c_MAX_IDX;
    end else if (r_random <= r_wired) begin
      r_random <= c_MAX_IDX;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lk_rsp_valid <= '0;
      lk_miss      <= '0;
      lk_invalid   <= '0;
      lk_dirty     <= '0;
      lk_cattr     <= '0;
      lk_paddr     <= '0;
    end else begin
      lk_rsp_valid <= lk_req;
      for (int p = 0; p < NUM_LOOKUP; p++) begin
        if (lk_req[p]) begin
          lk_miss[p]           <= !w_lk_hit[p];
          lk_invalid[p]        <= w_lk_hit[p] && !w_lk_page[p][0];
          lk_dirty[p]          <= w_lk_hit[p] && w_lk_page[p][1];
          lk_cattr[3*p +: 3]   <= w_lk_hit[p] ? w_lk_page[p][4:2] : 3'b000;
          lk_paddr[32*p +: 32] <= {(w_lk_hit[p] ? w_lk_page[p][24:5] : 20'h0),
                                   lk_vaddr[32*p +: 12]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tlbp_valid <= 1'b0;
      tlbp_index <= '0;
    end else begin
      tlbp_valid <= tlbp_req;
      if (tlbp_req) begin
        tlbp_index <= {!w_tp_hit, {(31 - IDX_W){1'b0}},
                       (w_tp_hit ? w_tp_idx : {IDX_W{1'b0}})};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlb_mp.sv
// ============================================================================
// Module  : tb_tlb_mp
// Brief   : Directed + randomized bench for tlb_mp against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tlb_mp;
  localparam int NE = 16;
  localparam int NL = 2;
  localparam int EW = 78;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     asid;
  logic [NL-1:0]  lk_req;
  logic [NL*32-1:0] lk_vaddr;
  logic [NL-1:0]  lk_rsp_valid, lk_miss, lk_invalid, lk_dirty;
  logic [NL*3-1:0] lk_cattr;
  logic [NL*32-1:0] lk_paddr;
  logic [IW-1:0]  rw_index;
  logic           tlbwi_we, tlbwr_we;
  logic [EW-1:0]  rw_wdata, rw_rdata;
  logic           wired_we;
  logic [IW-1:0]  wired_wdata, random;
  logic           tlbp_req;
  logic [31:0]    tlbp_entry_hi;
  logic           tlbp_valid;
  logic [31:0]    tlbp_index;
  logic           flush;

  always #5 clk = ~clk;

  tlb_mp #(.NUM_ENTRIES(NE), .NUM_LOOKUP(NL), .ENTRY_W(EW)) dut (
    .clk(clk), .reset(reset), .asid(asid), .lk_req(lk_req), .lk_vaddr(lk_vaddr),
    .lk_rsp_valid(lk_rsp_valid), .lk_miss(lk_miss), .lk_invalid(lk_invalid),
    .lk_dirty(lk_dirty), .lk_cattr(lk_cattr), .lk_paddr(lk_paddr),
    .rw_index(rw_index), .tlbwi_we(tlbwi_we), .tlbwr_we(tlbwr_we),
    .rw_wdata(rw_wdata), .rw_rdata(rw_rdata), .wired_we(wired_we),
    .wired_wdata(wired_wdata), .random(random), .tlbp_req(tlbp_req),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_valid(tlbp_valid),
    .tlbp_index(tlbp_index), .flush(flush)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(
      input logic [18:0] vpn2, input logic [7:0] a, input logic g,
      input logic [19:0] p0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] p1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, a, g, p0, c0, d0, v0, p1, c1, d1, v1};
  endfunction

  function automatic logic [EW-1:0] rnd_entry();
    return mk(19'($urandom_range(0, 7)), 8'($urandom_range(0, 3)), 1'($urandom),
              20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
              20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // ---------------- behavioural model ----------------
  logic [EW-1:0] m_ent [NE];
  int            m_random, m_wired;
  logic          e_valid [NL], e_miss [NL], e_inv [NL], e_dirty [NL];
  logic [2:0]    e_c [NL];
  logic [31:0]   e_pa [NL];
  logic          e_tv;
  logic [31:0]   e_ti;

  // First (lowest-index) entry whose VPN2 and ASID/global rule match.
  function automatic void m_find(input logic [18:0] vpn2, input logic [7:0] a,
                                 output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int i = 0; i < NE; i++) begin
      if (m_ent[i][77:59] == vpn2 && (m_ent[i][50] || m_ent[i][58:51] == a)) begin
        hit = 1;
        idx = i;
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit          h;
    int          ix;
    int          wi;
    logic [31:0] va;
    logic [EW-1:0] e;
    if (reset) begin
      for (int i = 0; i < NE; i++) m_ent[i] = '0;
      m_random = NE - 1;
      m_wired  = 0;
      for (int p = 0; p < NL; p++) begin
        e_valid[p] = 0; e_miss[p] = 0; e_inv[p] = 0; e_dirty[p] = 0;
        e_c[p] = 0; e_pa[p] = 0;
      end
      e_tv = 0;
      e_ti = 0;
    end else begin
      for (int p = 0; p < NL; p++) begin
        e_valid[p] = lk_req[p];
        if (lk_req[p]) begin
          va = lk_vaddr[32*p +: 32];
          m_find(va[31:13], asid, h, ix);
          e = m_ent[ix];
          if (!h) begin
            e_miss[p] = 1; e_inv[p] = 0; e_dirty[p] = 0; e_c[p] = 0;
            e_pa[p] = {20'h0, va[11:0]};
          end else if (va[12]) begin
            e_miss[p] = 0; e_inv[p] = !e[0]; e_dirty[p] = e[1]; e_c[p] = e[4:2];
            e_pa[p] = {e[24:5], va[11:0]};
          end else begin
            e_miss[p] = 0; e_inv[p] = !e[25]; e_dirty[p] = e[26]; e_c[p] = e[29:27];
            e_pa[p] = {e[49:30], va[11:0]};
          end
        end
      end
      e_tv = tlbp_req;
      if (tlbp_req) begin
        m_find(tlbp_entry_hi[31:13], tlbp_entry_hi[7:0], h, ix);
        e_ti = h ? ix : 32'h8000_0000;
      end
      wi = tlbwi_we ? int'(rw_index) : m_random;
      if (flush) for (int i = 0; i < NE; i++) begin m_ent[i][25] = 0; m_ent[i][0] = 0; end
      if (tlbwi_we || tlbwr_we) m_ent[wi] = rw_wdata;
      if (wired_we) begin
        m_wired  = wired_wdata;
        m_random = NE - 1;
      end else if (m_random <= m_wired) begin
        m_random = NE - 1;
      end else begin
        m_random = m_random - 1;
      end
    end
    #1;
    for (int p = 0; p < NL; p++) begin
      chk($sformatf("m_valid%0d", p), lk_rsp_valid[p], e_valid[p]);
      chk($sformatf("m_miss%0d", p), lk_miss[p], e_miss[p]);
      chk($sformatf("m_invalid%0d", p), lk_invalid[p], e_inv[p]);
      chk($sformatf("m_dirty%0d", p), lk_dirty[p], e_dirty[p]);
      chk($sformatf("m_cattr%0d", p), lk_cattr[3*p +: 3], e_c[p]);
      chk($sformatf("m_paddr%0d", p), lk_paddr[32*p +: 32], e_pa[p]);
    end
    chk("m_tlbp_valid", tlbp_valid, e_tv);
    chk("m_tlbp_index", tlbp_index, e_ti);
    chk("m_random", random, m_random);
    chk("m_rdata", rw_rdata, m_ent[rw_index]);
  end

  // ---------------- stimulus ----------------
  logic [EW-1:0] e1, e1g, e5, e7, e9, ef;
  int            exp_r;

  task automatic idle();
    lk_req = 0; tlbwi_we = 0; tlbwr_we = 0; wired_we = 0; tlbp_req = 0; flush = 0;
  endtask

  initial begin
    reset = 1; asid = 0; lk_vaddr = 0; rw_index = 0; rw_wdata = 0;
    wired_wdata = 0; tlbp_entry_hi = 0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_random", random, 15);
    chk("rst_valid", lk_rsp_valid, 0);
    chk("rst_paddr", lk_paddr, 0);
    chk("rst_tlbp", tlbp_index, 0);
    reset = 0;

    // basic hit
    e1 = mk(19'h40, 8'd5, 0, 20'h123, 3'd2, 1, 1, 20'h0, 3'd0, 0, 0);
    rw_index = 3; rw_wdata = e1; tlbwi_we = 1;
    @(negedge clk); idle();
    asid = 5; lk_vaddr[31:0] = 32'h0008_0ABC; lk_req = 2'b01;
    @(negedge clk); idle();
    chk("t1_valid", lk_rsp_valid[0], 1);
    chk("t1_miss", lk_miss[0], 0);
    chk("t1_paddr", lk_paddr[31:0], 32'h0012_3ABC);
    chk("t1_dirty", lk_dirty[0], 1);
    chk("t1_cattr", lk_cattr[2:0], 3'd2);

    // ASID mismatch, global, odd invalid
    asid = 6; lk_req = 2'b01;
    @(negedge clk); idle();
    chk("t2_asid_miss", lk_miss[0], 1);
    chk("t2_miss_paddr", lk_paddr[31:0], 32'h0000_0ABC);
    e1g = mk(19'h40, 8'd5, 1, 20'h123, 3'd2, 1, 1, 20'h0, 3'd0, 0, 0);
    rw_wdata = e1g; tlbwi_we = 1;
    @(negedge clk); idle(); lk_req = 2'b01;
    @(negedge clk); idle();
    chk("t2_global_hit", lk_miss[0], 0);
    chk("t2_global_paddr", lk_paddr[31:0], 32'h0012_3ABC);
    lk_vaddr[31:0] = 32'h0008_1000; lk_req = 2'b01;
    @(negedge clk); idle();
    chk("t2_odd_invalid", lk_invalid[0], 1);
    chk("t2_odd_nomiss", lk_miss[0], 0);

    // write/lookup same cycle sees old table
    e5 = mk(19'h100, 8'd6, 0, 20'h0, 3'd0, 0, 0, 20'hABCDE, 3'd3, 0, 1);
    rw_index = 5; rw_wdata = e5; tlbwi_we = 1;
    lk_vaddr[31:0] = 32'h0020_1234; lk_req = 2'b01;
    @(negedge clk); tlbwi_we = 0;
    chk("t3_old_table", lk_miss[0], 1);
    lk_vaddr[63:32] = 32'h0008_0ABC; lk_req = 2'b11;
    @(negedge clk); idle();
    chk("t3_new_hit", lk_miss[0], 0);
    chk("t3_p0_paddr", lk_paddr[31:0], 32'hABCD_E234);
    chk("t3_p1_paddr", lk_paddr[63:32], 32'h0012_3ABC);
    chk("t3_p0_cattr", lk_cattr[2:0], 3'd3);

    // Wired/Random sequence
    wired_wdata = 4; wired_we = 1;
    @(negedge clk); idle();
    for (int k = 0; k < 13; k++) begin
      exp_r = (k == 0 || k == 12) ? 15 : 15 - k;
      chk("t4_random_seq", random, exp_r);
      @(negedge clk);
    end
    for (int n = 0; n < 32 && random != 9; n++) @(negedge clk);
    chk("t4_wait_random9", random, 9);
    e9 = mk(19'h7, 8'd1, 0, 20'h99, 3'd1, 0, 1, 20'h98, 3'd1, 0, 1);
    rw_wdata = e9; tlbwr_we = 1;
    @(negedge clk); idle();
    rw_index = 9; #1;
    chk("t4_tlbwr_idx9", rw_rdata, e9);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); rw_wdata = rnd_entry(); tlbwr_we = 1;
    end
    @(negedge clk); idle();
    rw_index = 3; #1;
    chk("t4_wired_protect3", rw_rdata, e1g);
    rw_index = 0; #1;
    chk("t4_wired_protect0", rw_rdata, 0);

    // probe
    e7 = mk(19'h200, 8'd9, 0, 20'h77, 3'd0, 0, 1, 20'h0, 3'd0, 0, 0);
    rw_index = 7; rw_wdata = e7; tlbwi_we = 1;
    @(negedge clk); idle();
    tlbp_entry_hi = {19'h200, 5'h0, 8'd9}; tlbp_req = 1;
    @(negedge clk); idle();
    chk("t5_probe_valid", tlbp_valid, 1);
    chk("t5_probe_hit7", tlbp_index, 32'h0000_0007);
    tlbp_entry_hi = {19'h201, 5'h0, 8'd9}; tlbp_req = 1;
    @(negedge clk); idle();
    chk("t5_probe_absent", tlbp_index, 32'h8000_0000);
    rw_index = 2; rw_wdata = e7; tlbwi_we = 1;
    @(negedge clk); idle();
    tlbp_entry_hi = {19'h200, 5'h0, 8'd9}; tlbp_req = 1;
    @(negedge clk); idle();
    chk("t5_probe_dup", tlbp_index, 32'h0000_0002);

    // flush with concurrent write
    ef = mk(19'h300, 8'd0, 1, 20'h55, 3'd0, 1, 1, 20'h66, 3'd0, 1, 1);
    rw_index = 1; rw_wdata = ef; tlbwi_we = 1; flush = 1;
    @(negedge clk); idle();
    lk_vaddr = {32'h0008_0ABC, 32'h0060_0010}; lk_req = 2'b11;
    @(negedge clk); idle();
    chk("t6_written_valid", lk_invalid[0], 0);
    chk("t6_written_paddr", lk_paddr[31:0], 32'h0005_5010);
    chk("t6_flushed_invalid", lk_invalid[1], 1);

    // reset mid-run overrides write and lookup
    reset = 1; lk_req = 2'b11; tlbwi_we = 1; tlbp_req = 1;
    @(negedge clk); idle(); reset = 0;
    chk("t6_rst_random", random, 15);
    chk("t6_rst_valid", lk_rsp_valid, 0);
    chk("t6_rst_paddr", lk_paddr, 0);
    chk("t6_rst_tlbp", {tlbp_valid, tlbp_index}, 0);

    // randomized traffic, checked each cycle by the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 499) == 0);
      flush       = ($urandom_range(0, 63) == 0);
      wired_we    = ($urandom_range(0, 99) == 0);
      wired_wdata = IW'($urandom_range(0, 15));
      tlbwi_we    = ($urandom_range(0, 7) == 0);
      tlbwr_we    = ($urandom_range(0, 7) == 0);
      rw_index    = IW'($urandom);
      rw_wdata    = rnd_entry();
      asid        = 8'($urandom_range(0, 3));
      lk_req      = NL'($urandom);
      for (int p = 0; p < NL; p++)
        lk_vaddr[32*p +: 32] = {19'($urandom_range(0, 7)), 13'($urandom)};
      tlbp_req      = 1'($urandom);
      tlbp_entry_hi = {19'($urandom_range(0, 7)), 5'($urandom), 8'($urandom_range(0, 3))};
    end
    @(negedge clk); idle(); reset = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
